// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register bridge
package i2c_pkg;

    localparam int   I2C_BYTE_W    = 8;
    localparam logic I2C_DIR_WRITE = 1'b0;
    localparam logic I2C_DIR_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        WR,
        RD
    } bridge_state_t;

endpackage

// File: rtl/i2c_regfile.sv
// rtl/i2c_regfile.sv - 8-bit register file with registered read port and status override
module i2c_regfile
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [PTR_W-1:0]           i_wr_addr,
    input  logic [I2C_BYTE_W-1:0]      i_wr_data,
    input  logic [PTR_W-1:0]           i_rd_addr,
    input  logic [I2C_BYTE_W-1:0]      i_status,
    output logic [I2C_BYTE_W-1:0]      o_rd_data,
    output logic [NUM_REGS*I2C_BYTE_W-1:0] o_regs_out
);

    localparam logic [PTR_W-1:0] TOP_IDX = PTR_W'(NUM_REGS - 1);

    logic [I2C_BYTE_W-1:0] r_mem [NUM_REGS];
    logic [I2C_BYTE_W-1:0] r_rd_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            // Top index is a live window onto status, not storage
            r_rd_data <= (i_rd_addr == TOP_IDX) ? i_status : r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs_out[g*I2C_BYTE_W +: I2C_BYTE_W] = r_mem[g];
    end

endmodule

// File: rtl/i2c_reg_bridge.sv
// rtl/i2c_reg_bridge.sv - I2C byte stream to register map bridge; I2C_REG_AUTOINC_EN enables burst pointer increment
module i2c_reg_bridge
    import i2c_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    localparam int PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      xfer_start,
    input  logic                      xfer_rw,
    input  logic                      xfer_stop,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_valid,
    input  logic                      tx_ack,
    output logic [7:0]                tx_byte,
    input  logic [7:0]                status_in,
    output logic [NUM_REGS*8-1:0]     regs_out,
    output logic                      wr_strobe,
    output logic [PTR_W-1:0]          wr_addr,
    output logic                      err
);

    localparam logic [PTR_W-1:0] TOP_IDX = PTR_W'(NUM_REGS - 1);
`ifdef I2C_REG_AUTOINC_EN
    localparam logic [PTR_W-1:0] PTR_INC = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_INC = '0;
`endif

    bridge_state_t    r_state;
    logic [PTR_W-1:0] r_ptr;
    logic             r_err;
    logic             r_wr_strobe;
    logic [PTR_W-1:0] r_wr_addr;

    logic [PTR_W-1:0] w_ptr_next;
    logic             w_wr_en;
    logic             w_ptr_oor;

    assign w_ptr_oor = ({1'b0, rx_byte} >= 9'(NUM_REGS));

    // xfer_start discards any byte or ack arriving in the same cycle
    always_comb begin
        w_ptr_next = r_ptr;
        w_wr_en    = 1'b0;
        if (!xfer_start) begin
            case (r_state)
                PTR: if (rx_valid) w_ptr_next = rx_byte[PTR_W-1:0];
                WR: begin
                    if (rx_valid) begin
                        w_wr_en    = (r_ptr != TOP_IDX);
                        w_ptr_next = r_ptr + PTR_INC;
                    end
                end
                RD: if (tx_ack) w_ptr_next = r_ptr + PTR_INC;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_err       <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            r_ptr       <= w_ptr_next;
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_ptr;
            end
            if (xfer_start) begin
                r_state <= (xfer_rw == I2C_DIR_READ) ? RD : PTR;
            end else begin
                if (r_state == PTR && rx_valid) begin
                    r_state <= WR;
                    if (w_ptr_oor) begin
                        r_err <= 1'b1;
                    end
                end
                // A byte arriving with STOP is processed above before returning to IDLE
                if (xfer_stop) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    i2c_regfile #(
        .NUM_REGS (NUM_REGS),
        .PTR_W    (PTR_W)
    ) u_regfile (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_ptr),
        .i_wr_data  (rx_byte),
        .i_rd_addr  (w_ptr_next),
        .i_status   (status_in),
        .o_rd_data  (tx_byte),
        .o_regs_out (regs_out)
    );

    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign err       = r_err;

endmodule
